// File: rtl/param_shift_reg_pkg.sv
// Shared definitions for the parametrised shift register: mode encodings and
// the fill-count update rule.
package param_shift_reg_pkg;

    typedef enum logic [1:0] {
        SR_HOLD   = 2'b00,
        SR_SHIFT  = 2'b01,
        SR_LOAD   = 2'b10,
        SR_ROTATE = 2'b11
    } sr_mode_e;

    // Fill count after one clock: SHIFT adds a valid stage (saturating), LOAD fills all.
    function automatic int next_fill(input int cur, input int depth,
                                     input logic en, input logic [1:0] mode);
        int nxt;
        nxt = cur;
        if (en) begin
            case (mode)
                SR_SHIFT: nxt = (cur >= depth) ? depth : cur + 32'sd1;
                SR_LOAD:  nxt = depth;
                default:  nxt = cur;
            endcase
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/param_shift_reg_stage.sv
// One WIDTH-bit pipeline stage: sync reset, enable, and a shift/load next-value mux.
module sr_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] shift_d,
    input  logic [WIDTH-1:0] load_d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] next_s;

    // Next-value select between the chain neighbour and the parallel-load slice.
    always_comb begin
        next_s = shift_d;
        if (load) begin
            next_s = load_d;
        end else begin
            next_s = shift_d;
        end
    end

    // Stage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {WIDTH{1'b0}};
        end else if (en) begin
            q <= next_s;
        end
    end

endmodule

// File: rtl/param_shift_reg.sv
// Configurable delay line / serialiser: DEPTH stages of WIDTH bits with hold,
// shift, load and rotate modes, a tap mux, parallel output and fill tracking.
module param_shift_reg
    import param_shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [1:0]               mode,
    input  logic [WIDTH-1:0]         sin,
    input  logic [DEPTH*WIDTH-1:0]   pload,
    input  logic [SEL_W-1:0]         tap_sel,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         tap_q,
    output logic [DEPTH*WIDTH-1:0]   pout,
    output logic [CNT_W-1:0]         fill_cnt,
    output logic                     full
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q_s   [DEPTH];
    logic [WIDTH-1:0] shift_src_s [DEPTH];
    logic [WIDTH-1:0] head_src_s;
    logic [WIDTH-1:0] tap_s;
    logic             stage_en_s;
    logic             load_sel_s;
    logic [CNT_W-1:0] fill_next_s;
    logic [CNT_W-1:0] fill_cnt_r;
    logic             full_r;

    // Mode decode: which stages advance, and what feeds stage 0.
    always_comb begin
        stage_en_s = 1'b0;
        load_sel_s = 1'b0;
        head_src_s = sin;
        case (sr_mode_e'(mode))
            SR_SHIFT: begin
                stage_en_s = en;
                head_src_s = sin;
            end
            SR_LOAD: begin
                stage_en_s = en;
                load_sel_s = 1'b1;
            end
            SR_ROTATE: begin
                stage_en_s = en;
                head_src_s = stage_q_s[DEPTH-1];
            end
            default: begin
                stage_en_s = 1'b0;
            end
        endcase
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign shift_src_s[gi] = head_src_s;
        end else begin : g_body
            assign shift_src_s[gi] = stage_q_s[gi-1];
        end

        sr_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .en      (stage_en_s),
            .load    (load_sel_s),
            .shift_d (shift_src_s[gi]),
            .load_d  (pload[gi*WIDTH +: WIDTH]),
            .q       (stage_q_s[gi])
        );

        assign pout[gi*WIDTH +: WIDTH] = stage_q_s[gi];
    end

    assign fill_next_s = CNT_W'(next_fill(int'(fill_cnt_r), DEPTH, en, mode));

    // Fill counter and full flag are tracked together, independent of data values.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt_r <= {CNT_W{1'b0}};
            full_r     <= 1'b0;
        end else begin
            fill_cnt_r <= fill_next_s;
            full_r     <= (fill_next_s == FULL_CNT);
        end
    end

    // Tap mux; out-of-range selects fall through to zero.
    always_comb begin
        tap_s = {WIDTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            tap_s = (tap_sel == SEL_W'(i)) ? stage_q_s[i] : tap_s;
        end
    end

    assign q        = stage_q_s[DEPTH-1];
    assign tap_q    = tap_s;
    assign fill_cnt = fill_cnt_r;
    assign full     = full_r;

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against an array-based model of the stage contents.
module tb_param_shift_reg;

    typedef logic [7:0] stages_t [5];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [7:0]  sin = 8'h00;
    logic [31:0] pload = 32'h0;
    logic [7:0]  pl_hi = 8'h00;
    logic [1:0]  tap_sel = 2'd0;
    logic [2:0]  tap_sel5 = 3'd0;

    logic [7:0]  q, tap_q, q5, tap_q5;
    logic [31:0] pout;
    logic [39:0] pout5;
    logic [2:0]  fill_cnt, fill_cnt5;
    logic        full, full5;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    stages_t m4 = '{default: 8'h00};
    stages_t m5 = '{default: 8'h00};
    int      f4 = 0;
    int      f5 = 0;

    always #5 clk = ~clk;

    param_shift_reg #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pload(pload),
        .tap_sel(tap_sel), .q(q), .tap_q(tap_q), .pout(pout),
        .fill_cnt(fill_cnt), .full(full)
    );

    param_shift_reg #(.WIDTH(8), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pload({pl_hi, pload}),
        .tap_sel(tap_sel5), .q(q5), .tap_q(tap_q5), .pout(pout5),
        .fill_cnt(fill_cnt5), .full(full5)
    );

    // Stage contents after one edge: a shift pushes sin in at the front and drops
    // the back, a rotate moves the back element to the front.
    function automatic stages_t model_next(stages_t cur, int d, logic r, logic e,
                                           logic [1:0] md, logic [7:0] s, logic [39:0] pl);
        stages_t nx;
        nx = cur;
        if (r) begin
            nx = '{default: 8'h00};
        end else if (e && md == 2'b01) begin
            for (int i = 0; i < d; i++) nx[i] = (i == 0) ? s : cur[i-1];
        end else if (e && md == 2'b10) begin
            for (int i = 0; i < d; i++) nx[i] = pl[i*8 +: 8];
        end else if (e && md == 2'b11) begin
            for (int i = 0; i < d; i++) nx[i] = cur[(i + d - 1) % d];
        end
        return nx;
    endfunction

    function automatic int model_fill(int cur, int d, logic r, logic e, logic [1:0] md);
        if (r) return 0;
        if (e && md == 2'b01) return (cur < d) ? cur + 1 : d;
        if (e && md == 2'b10) return d;
        return cur;
    endfunction

    function automatic logic [39:0] pack(stages_t m, int d);
        logic [39:0] p;
        p = 40'h0;
        for (int i = 0; i < d; i++) p[i*8 +: 8] = m[i];
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model advances on the same edge as the DUTs.
    always @(posedge clk) begin
        m4 <= model_next(m4, 4, rst, en, mode, sin, {8'h00, pload});
        m5 <= model_next(m5, 5, rst, en, mode, sin, {pl_hi, pload});
        f4 <= model_fill(f4, 4, rst, en, mode);
        f5 <= model_fill(f5, 5, rst, en, mode);
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q4", 64'(q), 64'(m4[3]));
            chk("pout4", 64'(pout), 64'(pack(m4, 4)));
            chk("fill4", 64'(fill_cnt), 64'(f4));
            chk("full4", 64'(full), 64'(f4 == 4));
            chk("tap4", 64'(tap_q), 64'(m4[tap_sel]));
            chk("q5", 64'(q5), 64'(m5[4]));
            chk("pout5", 64'(pout5), 64'(pack(m5, 5)));
            chk("fill5", 64'(fill_cnt5), 64'(f5));
            chk("full5", 64'(full5), 64'(f5 == 5));
            chk("tap5", 64'(tap_q5), (tap_sel5 < 3'd5) ? 64'(m5[tap_sel5]) : 64'h0);
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [7:0] s, input logic [31:0] pl);
        rst = r; en = e; mode = md; sin = s; pload = pl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fill_vals [4];
        logic [7:0] tap_exp [4];
        fill_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        tap_exp   = '{8'h44, 8'h33, 8'h22, 8'h11};
        pl_hi = 8'hEE;
        #1;

        // Reset with a shift pending on the inputs.
        step(1'b1, 1'b1, 2'b01, 8'hFF, 32'h0);
        step(1'b1, 1'b1, 2'b01, 8'hFF, 32'h0);
        chk_on = 1'b1;
        chk("rst_q", 64'(q), 64'h0);
        chk("rst_pout", 64'(pout), 64'h0);
        chk("rst_fill", 64'(fill_cnt), 64'h0);
        chk("rst_full", 64'(full), 64'h0);

        // Fill via SHIFT.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'b01, fill_vals[i], 32'h0);
            chk("fill_cnt_ramp", 64'(fill_cnt), 64'(i + 1));
        end
        chk("fill_q", 64'(q), 64'h11);
        chk("fill_pout", 64'(pout), 64'h11223344);
        chk("fill_full", 64'(full), 64'h1);

        // Tap sweep, combinational.
        for (int i = 0; i < 4; i++) begin
            tap_sel = 2'(i);
            #1;
            chk("tap_sweep", 64'(tap_q), 64'(tap_exp[i]));
        end

        step(1'b0, 1'b1, 2'b01, 8'h55, 32'h0);
        chk("shift5_q", 64'(q), 64'h22);
        chk("shift5_fill", 64'(fill_cnt), 64'h4);

        // LOAD then ROTATE.
        step(1'b0, 1'b1, 2'b10, 8'h00, 32'hDDCCBBAA);
        chk("load_q", 64'(q), 64'hDD);
        tap_sel5 = 3'd7;
        #1;
        chk("tap5_oob", 64'(tap_q5), 64'h0);
        tap_sel5 = 3'd4;
        #1;
        chk("tap5_top", 64'(tap_q5), 64'hEE);
        step(1'b0, 1'b1, 2'b11, 8'h77, 32'h0);
        chk("rot1_s0", 64'(pout[7:0]), 64'hDD);
        chk("rot1_q", 64'(q), 64'hCC);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b11, 8'h77, 32'h0);
        chk("rot4_pout", 64'(pout), 64'hDDCCBBAA);
        chk("rot4_fill", 64'(fill_cnt), 64'h4);

        // Enable / HOLD gating.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b01, 8'h5A, 32'h0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 2'b00, 8'hA5, 32'h0);
        chk("hold_pout", 64'(pout), 64'hDDCCBBAA);
        chk("hold_fill", 64'(fill_cnt), 64'h4);

        // Reset mid-operation.
        step(1'b1, 1'b1, 2'b10, 8'h00, 32'h0);
        step(1'b0, 1'b1, 2'b01, 8'h01, 32'h0);
        step(1'b0, 1'b1, 2'b01, 8'h02, 32'h0);
        step(1'b1, 1'b1, 2'b01, 8'h03, 32'h0);
        step(1'b0, 1'b1, 2'b01, 8'h99, 32'h0);
        chk("mid_rst_pout", 64'(pout), 64'h00000099);
        chk("mid_rst_fill", 64'(fill_cnt), 64'h1);
        chk("mid_rst_full", 64'(full), 64'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            tap_sel  = 2'($urandom_range(0, 3));
            tap_sel5 = 3'($urandom_range(0, 7));
            pl_hi    = 8'($urandom);
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 32'($urandom));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
